// File: rtl/dwt_tile_scheduler.sv
// ----------------------------------------------------------------------------
// dwt_tile_scheduler
//
// Frame-level sequencer for the DWT front end. A frame is walked tile by tile
// in raster order (TILES_X across, TILES_Y down). The frame-buffer base
// address of each tile is built incrementally, with no multipliers. The block
// owns two ping-pong tile banks (o1 = bank 0, o2 = bank 1) and hands each one
// alternately to the tile loader (write) and to the DWT engine (read). This
// lets the load of tile n+1 overlap the transform of tile n.
//
// Ports
//   clk_dwt_i     DWT clock, rising edge
//   rst_i         asynchronous active-high reset
//   rst_syn_i     synchronous clear, same effect as rst_i
//   start_cpu_i   frame request level; a rising edge starts a frame
//   ld_start_o    1-cycle pulse: loader starts tile ld_base_o into ld_bank_o
//   ld_bank_o     loader target bank (0 = o1, 1 = o2)
//   ld_base_o     frame-buffer base word address of the tile being loaded
//   ld_idx_o      raster index of the tile being loaded
//   ld_done_i     1-cycle pulse: loader finished the tile
//   dwt_start_o   1-cycle pulse: DWT engine may consume dwt_bank_o
//   dwt_bank_o    bank granted to the DWT engine
//   dwt_done_i    1-cycle pulse: DWT engine released its bank
//   bank_full_o   bit b set = bank b holds a loaded, unconsumed tile
//   frame_busy_o  high from frame start until frame_done_o
//   frame_done_o  1-cycle pulse after the last tile's dwt_done_i
//   proto_err_o   sticky: a done pulse arrived with no grant outstanding
// ----------------------------------------------------------------------------
module dwt_tile_scheduler #(
    parameter int TILES_X   = 5,
    parameter int TILES_Y   = 5,
    parameter int TILE_STEP = 64,
    parameter int ROW_STEP  = 40960,
    parameter int ADDR_W    = 18,
    parameter int IDX_W     = 5
) (
    input  logic              clk_dwt_i,
    input  logic              rst_i,
    input  logic              rst_syn_i,
    input  logic              start_cpu_i,
    output logic              ld_start_o,
    output logic              ld_bank_o,
    output logic [ADDR_W-1:0] ld_base_o,
    output logic [IDX_W-1:0]  ld_idx_o,
    input  logic              ld_done_i,
    output logic              dwt_start_o,
    output logic              dwt_bank_o,
    input  logic              dwt_done_i,
    output logic [1:0]        bank_full_o,
    output logic              frame_busy_o,
    output logic              frame_done_o,
    output logic              proto_err_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILES_X * TILES_Y - 1);
    localparam logic [IDX_W-1:0] LAST_TX  = IDX_W'(TILES_X - 1);

    typedef enum logic [1:0] {
        L_IDLE,
        L_ISSUE,
        L_WAIT
    } lState_t;

    typedef enum logic {
        D_IDLE,
        D_RUN
    } dState_t;

    lState_t           lState_q, lState_d;
    dState_t           dState_q, dState_d;
    logic              startPrev_q, startPrev_d;
    logic              startArmed_q, startArmed_d;
    logic              frameBusy_q, frameBusy_d;
    logic              frameDone_q, frameDone_d;
    logic              protoErr_q, protoErr_d;
    logic [1:0]        bankFull_q, bankFull_d;
    logic              ldBank_q, ldBank_d;
    logic [ADDR_W-1:0] ldBase_q, ldBase_d;
    logic [ADDR_W-1:0] rowBase_q, rowBase_d;
    logic [IDX_W-1:0]  ldIdx_q, ldIdx_d;
    logic [IDX_W-1:0]  tx_q, tx_d;
    logic [IDX_W-1:0]  ty_q, ty_d;
    logic              dwtBank_q, dwtBank_d;
    logic [IDX_W-1:0]  dwtCnt_q, dwtCnt_d;

    logic              startRise;
    logic              ldStartPulse;
    logic              dwtStartPulse;
    logic [1:0]        bankSet;
    logic [1:0]        bankClr;

    // State registers. The asynchronous reset and the synchronous clear both
    // return every register to its idle value. The synchronous clear is folded
    // into the next-state logic below.
    always_ff @(posedge clk_dwt_i or posedge rst_i) begin
        if (rst_i) begin
            lState_q     <= L_IDLE;
            dState_q     <= D_IDLE;
            startPrev_q  <= 1'b0;
            startArmed_q <= 1'b0;
            frameBusy_q  <= 1'b0;
            frameDone_q  <= 1'b0;
            protoErr_q   <= 1'b0;
            bankFull_q   <= 2'b00;
            ldBank_q     <= 1'b0;
            ldBase_q     <= '0;
            rowBase_q    <= '0;
            ldIdx_q      <= '0;
            tx_q         <= '0;
            ty_q         <= '0;
            dwtBank_q    <= 1'b0;
            dwtCnt_q     <= '0;
        end else begin
            lState_q     <= lState_d;
            dState_q     <= dState_d;
            startPrev_q  <= startPrev_d;
            startArmed_q <= startArmed_d;
            frameBusy_q  <= frameBusy_d;
            frameDone_q  <= frameDone_d;
            protoErr_q   <= protoErr_d;
            bankFull_q   <= bankFull_d;
            ldBank_q     <= ldBank_d;
            ldBase_q     <= ldBase_d;
            rowBase_q    <= rowBase_d;
            ldIdx_q      <= ldIdx_d;
            tx_q         <= tx_d;
            ty_q         <= ty_d;
            dwtBank_q    <= dwtBank_d;
            dwtCnt_q     <= dwtCnt_d;
        end
    end

    // Next-state logic for the frame start detector, the loader FSM, the DWT
    // FSM and the shared bank-occupancy flags.
    always_comb begin
        lState_d      = lState_q;
        dState_d      = dState_q;
        frameBusy_d   = frameBusy_q;
        frameDone_d   = 1'b0;
        bankFull_d    = bankFull_q;
        ldBank_d      = ldBank_q;
        ldBase_d      = ldBase_q;
        rowBase_d     = rowBase_q;
        ldIdx_d       = ldIdx_q;
        tx_d          = tx_q;
        ty_d          = ty_q;
        dwtBank_d     = dwtBank_q;
        dwtCnt_d      = dwtCnt_q;
        ldStartPulse  = 1'b0;
        dwtStartPulse = 1'b0;
        bankSet       = 2'b00;
        bankClr       = 2'b00;

        // After reset the edge detector stays disarmed until start_cpu has
        // been seen low. A request level held through reset therefore does
        // not look like a fresh rising edge.
        startPrev_d  = start_cpu_i;
        startArmed_d = startArmed_q | ~start_cpu_i;
        startRise    = start_cpu_i & ~startPrev_q & startArmed_q & ~frameBusy_q;

        if (startRise) begin
            frameBusy_d = 1'b1;
            dwtBank_d   = 1'b0;
            dwtCnt_d    = '0;
        end

        // Loader: issue a tile once its target bank is empty, then wait for
        // the loader to finish it. Address and index move only on ld_done,
        // so they stay stable for the whole load.
        unique case (lState_q)
            L_IDLE: begin
                if (startRise) begin
                    lState_d  = L_ISSUE;
                    ldBank_d  = 1'b0;
                    ldBase_d  = '0;
                    rowBase_d = '0;
                    ldIdx_d   = '0;
                    tx_d      = '0;
                    ty_d      = '0;
                end
            end
            L_ISSUE: begin
                if (!bankFull_q[ldBank_q]) begin
                    ldStartPulse = 1'b1;
                    lState_d     = L_WAIT;
                end
            end
            L_WAIT: begin
                if (ld_done_i) begin
                    bankSet[ldBank_q] = 1'b1;
                    ldBank_d          = ~ldBank_q;
                    if (ldIdx_q == LAST_IDX) begin
                        lState_d = L_IDLE;
                    end else begin
                        lState_d = L_ISSUE;
                        ldIdx_d  = ldIdx_q + 1'b1;
                        // The next tile across is one TILE_STEP further.
                        // Wrapping to a new row restarts from the
                        // accumulated row base.
                        if (tx_q < LAST_TX) begin
                            tx_d     = tx_q + 1'b1;
                            ldBase_d = ldBase_q + ADDR_W'(TILE_STEP);
                        end else begin
                            tx_d      = '0;
                            ty_d      = ty_q + 1'b1;
                            rowBase_d = rowBase_q + ADDR_W'(ROW_STEP);
                            ldBase_d  = rowBase_q + ADDR_W'(ROW_STEP);
                        end
                    end
                end
            end
            default: lState_d = L_IDLE;
        endcase

        // DWT engine: grant the next bank in ping-pong order as soon as it is
        // full. The last consumed tile closes the frame.
        unique case (dState_q)
            D_IDLE: begin
                if (frameBusy_q && bankFull_q[dwtBank_q]) begin
                    dwtStartPulse = 1'b1;
                    dState_d      = D_RUN;
                end
            end
            D_RUN: begin
                if (dwt_done_i) begin
                    bankClr[dwtBank_q] = 1'b1;
                    dwtBank_d          = ~dwtBank_q;
                    dState_d           = D_IDLE;
                    if (dwtCnt_q == LAST_IDX) begin
                        frameDone_d = 1'b1;
                        frameBusy_d = 1'b0;
                    end else begin
                        dwtCnt_d = dwtCnt_q + 1'b1;
                    end
                end
            end
            default: dState_d = D_IDLE;
        endcase

        // A simultaneous fill and release always target different banks, so
        // both updates can be applied in the same cycle.
        bankFull_d = (bankFull_q & ~bankClr) | bankSet;

        protoErr_d = protoErr_q
                   | (ld_done_i  && (lState_q != L_WAIT))
                   | (dwt_done_i && (dState_q != D_RUN));

        if (rst_syn_i) begin
            lState_d     = L_IDLE;
            dState_d     = D_IDLE;
            startPrev_d  = 1'b0;
            startArmed_d = 1'b0;
            frameBusy_d  = 1'b0;
            frameDone_d  = 1'b0;
            protoErr_d   = 1'b0;
            bankFull_d   = 2'b00;
            ldBank_d     = 1'b0;
            ldBase_d     = '0;
            rowBase_d    = '0;
            ldIdx_d      = '0;
            tx_d         = '0;
            ty_d         = '0;
            dwtBank_d    = 1'b0;
            dwtCnt_d     = '0;
        end
    end

    assign ld_start_o   = ldStartPulse;
    assign ld_bank_o    = ldBank_q;
    assign ld_base_o    = ldBase_q;
    assign ld_idx_o     = ldIdx_q;
    assign dwt_start_o  = dwtStartPulse;
    assign dwt_bank_o   = dwtBank_q;
    assign bank_full_o  = bankFull_q;
    assign frame_busy_o = frameBusy_q;
    assign frame_done_o = frameDone_q;
    assign proto_err_o  = protoErr_q;

endmodule
